mips_cpu_decode_stage: RTL and testbench

Instruction-decode / register-read stage of the Harvard MIPS core. It accepts fetched instructions and their PC from the fetch stage and decodes them. It reads operands from the architectural register file, which it owns, and hands a registered decode bundle to the execute stage. Hazards are resolved with a per-register scoreboard; results come back through the writeback port.

---
 rtl/mips_cpu_pkg.sv | 79 +++++++
 rtl/mips_cpu_regfile.sv | 42 ++++
 rtl/mips_cpu_decode_stage.sv | 155 +++++++++++++++
 tb/tb_mips_cpu_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared opcode/funct encodings, register indices and the
//               instruction decoder used by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    ADDIU = 6'b001001,
    LW    = 6'b100011,
    SW    = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    JR = 6'b001000
  } functcode_t;

  localparam logic [4:0] ZERO = 5'd0;
  localparam logic [4:0] V0   = 5'd2;

  // Control information extracted from one instruction word
  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_jr;
    logic       illegal;
  } decode_t;

  // Pure decode of an instruction word; dest is left 0 when nothing is written
  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d = '0;
    case (opcode_t'(instr[31:26]))
      RTYPE: begin
        d.use_rs = 1'b1;
        if (instr[5:0] == JR) begin
          d.is_jr = 1'b1;
        end else begin
          d.use_rt    = 1'b1;
          d.dest      = instr[15:11];
          d.reg_write = 1'b1;
        end
      end
      ADDIU: begin
        d.use_rs    = 1'b1;
        d.dest      = instr[20:16];
        d.reg_write = 1'b1;
      end
      LW: begin
        d.use_rs    = 1'b1;
        d.dest      = instr[20:16];
        d.reg_write = 1'b1;
        d.mem_read  = 1'b1;
      end
      SW: begin
        d.use_rs    = 1'b1;
        d.use_rt    = 1'b1;
        d.mem_write = 1'b1;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    // $0 is never a real destination
    if (d.dest == ZERO) begin
      d.reg_write = 1'b0;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_regfile
// Description : 32x32 architectural register file, two combinational read
//               ports, one synchronous write port, $0 hardwired to zero,
//               live tap of $2.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_regfile
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  output logic [31:0] register_v0
);

  logic [31:0] regs [32];

  // Synchronous write port; $0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a   = (rd_addr_a == ZERO) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b   = (rd_addr_b == ZERO) ? 32'd0 : regs[rd_addr_b];
  assign register_v0 = regs[V0];

endmodule
`default_nettype wire

// File: rtl/mips_cpu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_decode_stage
// Description : Instruction decode / register read stage. Owns the register
//               file and a per-register scoreboard, stalls on RAW/WAW hazards
//               and presents a registered decode bundle to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_decode_stage
  import mips_cpu_pkg::*;
#(
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_sext,
  output logic [31:0] ex_imm_zext,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_is_jr,
  output logic        ex_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] register_v0
);

  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  decode_t     dec;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        rs_bypass;
  logic        rt_bypass;
  logic        rs_hazard;
  logic        rt_hazard;
  logic        waw_hazard;
  logic        stall;
  logic        accept;
  logic [31:0] rs_value;
  logic [31:0] rt_value;

  assign rs_addr = if_instr[25:21];
  assign rt_addr = if_instr[20:16];
  assign dec     = decode_instr(if_instr);

  mips_cpu_regfile u_regfile (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wb_en & clk_enable),
    .wr_addr     (wb_addr),
    .wr_data     (wb_data),
    .rd_addr_a   (rs_addr),
    .rd_data_a   (rf_rs_data),
    .rd_addr_b   (rt_addr),
    .rd_data_b   (rf_rt_data),
    .register_v0 (register_v0)
  );

  // Hazard detection, same-cycle writeback forwarding and fetch handshake
  always_comb begin
    rs_bypass  = BYPASS_WB && wb_en && (wb_addr == rs_addr) && (rs_addr != ZERO);
    rt_bypass  = BYPASS_WB && wb_en && (wb_addr == rt_addr) && (rt_addr != ZERO);
    rs_hazard  = dec.use_rs && pending[rs_addr] && !rs_bypass;
    rt_hazard  = dec.use_rt && pending[rt_addr] && !rt_bypass;
    // WAW: the destination still has an older result outstanding
    waw_hazard = dec.reg_write && pending[dec.dest];
    stall      = rs_hazard || rt_hazard || waw_hazard;
    if_ready   = clk_enable && !stall && (!ex_valid || ex_ready);
    accept     = if_valid && if_ready;
    rs_value   = rs_bypass ? wb_data : rf_rs_data;
    rt_value   = rt_bypass ? wb_data : rf_rt_data;
  end

  // Scoreboard next state: writeback clears, a newly issued writer sets (set wins)
  always_comb begin
    pending_next = pending;
    if (wb_en) begin
      pending_next[wb_addr] = 1'b0;
    end
    if (accept && dec.reg_write) begin
      pending_next[dec.dest] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (clk_enable) begin
      pending <= pending_next;
    end
  end

  // Decode bundle register: load on transfer, hold while execute back-pressures
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_instr     <= '0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm_sext  <= '0;
      ex_imm_zext  <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_is_jr     <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (clk_enable) begin
      if (accept) begin
        ex_valid     <= 1'b1;
        ex_pc        <= if_pc;
        ex_instr     <= if_instr;
        ex_opcode    <= if_instr[31:26];
        ex_funct     <= if_instr[5:0];
        ex_rs_data   <= rs_value;
        ex_rt_data   <= rt_value;
        ex_imm_sext  <= {{16{if_instr[15]}}, if_instr[15:0]};
        ex_imm_zext  <= {16'd0, if_instr[15:0]};
        ex_dest      <= dec.dest;
        ex_reg_write <= dec.reg_write;
        ex_mem_read  <= dec.mem_read;
        ex_mem_write <= dec.mem_write;
        ex_is_jr     <= dec.is_jr;
        ex_illegal   <= dec.illegal;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_decode_stage
// Description : Directed self-checking bench; one instance with writeback
//               bypass and one without, driven by the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  // Outputs of the bypassing instance
  logic        if_ready, ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm_sext, ex_imm_zext, register_v0;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_jr, ex_illegal;

  // Outputs of the non-bypassing instance
  logic        nb_if_ready, nb_ex_valid;
  logic [31:0] nb_ex_pc, nb_ex_instr, nb_ex_rs_data, nb_ex_rt_data, nb_ex_imm_sext, nb_ex_imm_zext, nb_register_v0;
  logic [5:0]  nb_ex_opcode, nb_ex_funct;
  logic [4:0]  nb_ex_dest;
  logic        nb_ex_reg_write, nb_ex_mem_read, nb_ex_mem_write, nb_ex_is_jr, nb_ex_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_cpu_decode_stage #(.BYPASS_WB(1'b1)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm_sext(ex_imm_sext), .ex_imm_zext(ex_imm_zext), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_is_jr(ex_is_jr), .ex_illegal(ex_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .register_v0(register_v0)
  );

  mips_cpu_decode_stage #(.BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .if_valid(if_valid), .if_ready(nb_if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ex_valid(nb_ex_valid), .ex_ready(ex_ready), .ex_pc(nb_ex_pc), .ex_instr(nb_ex_instr),
    .ex_opcode(nb_ex_opcode), .ex_funct(nb_ex_funct), .ex_rs_data(nb_ex_rs_data), .ex_rt_data(nb_ex_rt_data),
    .ex_imm_sext(nb_ex_imm_sext), .ex_imm_zext(nb_ex_imm_zext), .ex_dest(nb_ex_dest),
    .ex_reg_write(nb_ex_reg_write), .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write),
    .ex_is_jr(nb_ex_is_jr), .ex_illegal(nb_ex_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .register_v0(nb_register_v0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch-side presentation of one instruction
  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic writeback(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_instr", ex_instr, 32'd0);
    check("rst_ex_dest", {27'd0, ex_dest}, 32'd0);
    check("rst_v0", register_v0, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);

    // ADDIU $2,$0,5 then writeback $2=5
    present(32'h24020005, 32'h100);
    tick();
    if_valid = 1'b0;
    check("addiu_valid", {31'd0, ex_valid}, 32'd1);
    check("addiu_dest", {27'd0, ex_dest}, 32'd2);
    check("addiu_sext", ex_imm_sext, 32'd5);
    check("addiu_regw", {31'd0, ex_reg_write}, 32'd1);
    check("addiu_pc", ex_pc, 32'h100);
    check("addiu_opcode", {26'd0, ex_opcode}, 32'h9);
    writeback(5'd2, 32'd5);
    check("v0_after_wb", register_v0, 32'd5);
    check("addiu_drained", {31'd0, ex_valid}, 32'd0);

    // ADDIU $3,$0,7 then ADDU $4,$3,$3 with writeback held off 3 cycles
    present(32'h24030007, 32'h104);
    tick();
    present(32'h00632021, 32'h108);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("raw_stall_byp", {31'd0, if_ready}, 32'd0);
      check("raw_stall_nb", {31'd0, nb_if_ready}, 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
    #1;
    check("byp_release", {31'd0, if_ready}, 32'd1);
    check("nb_still_stall", {31'd0, nb_if_ready}, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    check("byp_addu_valid", {31'd0, ex_valid}, 32'd1);
    check("byp_addu_rs", ex_rs_data, 32'd7);
    check("byp_addu_rt", ex_rt_data, 32'd7);
    check("byp_addu_dest", {27'd0, ex_dest}, 32'd4);
    check("byp_waw_stall", {31'd0, if_ready}, 32'd0);
    check("nb_release", {31'd0, nb_if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("nb_addu_valid", {31'd0, nb_ex_valid}, 32'd1);
    check("nb_addu_rs", nb_ex_rs_data, 32'd7);
    check("nb_addu_rt", nb_ex_rt_data, 32'd7);
    check("byp_no_dup", {31'd0, ex_valid}, 32'd0);
    writeback(5'd4, 32'd14);

    // Execute back-pressure for 4 cycles
    ex_ready = 1'b0;
    present(32'h24050011, 32'h10C);
    tick();
    present(32'h24060022, 32'h110);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_if_ready", {31'd0, if_ready}, 32'd0);
      check("bp_valid", {31'd0, ex_valid}, 32'd1);
      check("bp_instr", ex_instr, 32'h24050011);
      check("bp_pc", ex_pc, 32'h10C);
      check("bp_dest", {27'd0, ex_dest}, 32'd5);
      check("bp_imm", ex_imm_sext, 32'h11);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("bp_next_instr", ex_instr, 32'h24060022);
    check("bp_next_pc", ex_pc, 32'h110);
    writeback(5'd5, 32'h11);
    writeback(5'd6, 32'h100);

    // SW $5,-4($6)
    present(32'hACC5FFFC, 32'h114);
    tick();
    if_valid = 1'b0;
    check("sw_sext", ex_imm_sext, 32'hFFFFFFFC);
    check("sw_zext", ex_imm_zext, 32'h0000FFFC);
    check("sw_memw", {31'd0, ex_mem_write}, 32'd1);
    check("sw_regw", {31'd0, ex_reg_write}, 32'd0);
    check("sw_rs", ex_rs_data, 32'h100);
    check("sw_rt", ex_rt_data, 32'h11);

    // Writes to $0 are dropped
    writeback(5'd0, 32'hDEADBEEF);
    present(32'h00000821, 32'h118);
    tick();
    if_valid = 1'b0;
    check("zero_rs", ex_rs_data, 32'd0);
    check("zero_rt", ex_rt_data, 32'd0);
    check("zero_dest", {27'd0, ex_dest}, 32'd1);

    // LW $7,8($0)
    present(32'h8C070008, 32'h11C);
    tick();
    if_valid = 1'b0;
    check("lw_memr", {31'd0, ex_mem_read}, 32'd1);
    check("lw_dest", {27'd0, ex_dest}, 32'd7);
    check("lw_regw", {31'd0, ex_reg_write}, 32'd1);

    // JR $31
    present(32'h03E00008, 32'h120);
    tick();
    if_valid = 1'b0;
    check("jr_flag", {31'd0, ex_is_jr}, 32'd1);
    check("jr_regw", {31'd0, ex_reg_write}, 32'd0);

    // Illegal opcode 0x3F
    present(32'hFC000000, 32'h124);
    tick();
    if_valid = 1'b0;
    check("ill_flag", {31'd0, ex_illegal}, 32'd1);
    check("ill_valid", {31'd0, ex_valid}, 32'd1);
    check("ill_regw", {31'd0, ex_reg_write}, 32'd0);
    check("ill_memr", {31'd0, ex_mem_read}, 32'd0);

    // clk_enable low freezes everything, including register writes
    tick();
    clk_enable = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h99;
    #1;
    check("ce_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    clk_enable = 1'b1;
    wb_en = 1'b0;
    check("ce_v0_hold", register_v0, 32'd5);

    // Reset with pending $3 and a stalled dependent instruction
    present(32'h24030001, 32'h200);
    tick();
    present(32'h00632021, 32'h204);
    #1;
    check("pre_rst_stall", {31'd0, if_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("mid_rst_pc", ex_pc, 32'd0);
    check("mid_rst_v0", register_v0, 32'd0);
    check("mid_rst_ready", {31'd0, if_ready}, 32'd1);
    check("mid_rst_ready_nb", {31'd0, nb_if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_instr", ex_instr, 32'h00632021);
    check("post_rst_rs", ex_rs_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
